// File: rtl/seg_display_scheduler.sv
// Scan-clock generator and source arbiter for the four-digit seven-segment mux.
// Chooses the displayed word (live or event snapshot) and which half is shown.
module seg_display_scheduler #(
    parameter int SCAN_DIV   = 50000,
    parameter int PAGE_SCANS = 256,
    parameter int HOLD_PAGES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Data0,
    input  logic [31:0] Data1,
    input  logic [31:0] Data2,
    input  logic [1:0]  Req,
    input  logic        Freeze,
    output logic        CLK_S,
    output logic [31:0] Data,
    output logic        Sel,
    output logic [1:0]  Src,
    output logic [1:0]  Ack
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;
    localparam int HLD_W = $clog2(HOLD_PAGES + 1);

    typedef enum logic {ST_LIVE, ST_HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_clk_s;
    logic [1:0]        r_digit;
    logic [FRM_W-1:0]  r_frame_cnt, w_frame_nxt;
    logic [HLD_W-1:0]  r_hold_cnt, w_hold_nxt;
    logic              r_sel, w_sel_nxt;
    logic [1:0]        r_src, w_src_nxt;
    logic [31:0]       r_data, w_data_nxt;
    logic [1:0]        r_ack;
    logic [1:0]        r_req_q;
    logic              r_pend_vld;
    logic [1:0]        r_pend_src;
    logic [31:0]       r_pend_data;

    logic              w_div_wrap;
    logic              w_tick;
    logic              w_frame_bnd;
    logic              w_frame_wrap;
    logic              w_page_tgl;
    logic [1:0]        w_req_new;

    assign w_div_wrap   = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_tick       = w_div_wrap && !r_clk_s;
    assign w_frame_bnd  = w_tick && (r_digit == 2'd3);
    assign w_frame_wrap = (r_frame_cnt == FRM_W'(PAGE_SCANS - 1));
    assign w_page_tgl   = w_frame_bnd && !Freeze && w_frame_wrap;
    // Ack only on the rising edge of a request bit so a held Req acks once.
    assign w_req_new    = Req & ~r_req_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_cnt <= '0;
            r_clk_s   <= 1'b0;
            r_digit   <= 2'd0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap)
                r_clk_s <= ~r_clk_s;
            if (w_tick)
                r_digit <= r_digit + 2'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_LIVE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_sel_nxt   = r_sel;
        w_hold_nxt  = r_hold_cnt;
        w_frame_nxt = r_frame_cnt;
        w_data_nxt  = (r_state == ST_LIVE) ? Data0 : r_data;
        if (w_frame_bnd) begin
            if (!Freeze)
                w_frame_nxt = w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
            // A pending event wins over both page toggling and hold expiry.
            if (r_pend_vld) begin
                w_state_nxt = ST_HOLD;
                w_src_nxt   = r_pend_src;
                w_data_nxt  = r_pend_data;
                w_sel_nxt   = 1'b0;
                w_frame_nxt = '0;
                w_hold_nxt  = '0;
            end else if (w_page_tgl) begin
                if (r_state == ST_HOLD && r_hold_cnt == HLD_W'(HOLD_PAGES - 1)) begin
                    w_state_nxt = ST_LIVE;
                    w_src_nxt   = 2'd0;
                    w_sel_nxt   = 1'b0;
                    w_data_nxt  = Data0;
                    w_hold_nxt  = '0;
                end else begin
                    w_sel_nxt = ~r_sel;
                    if (r_state == ST_HOLD)
                        w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            r_sel       <= 1'b0;
            r_src       <= 2'd0;
            r_data      <= 32'd0;
            r_ack       <= 2'b00;
            r_req_q     <= 2'b00;
            r_pend_vld  <= 1'b0;
            r_pend_src  <= 2'd0;
        end else begin
            r_frame_cnt <= w_frame_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_sel       <= w_sel_nxt;
            r_src       <= w_src_nxt;
            r_data      <= w_data_nxt;
            r_req_q     <= Req;
            r_ack       <= w_req_new[1] ? 2'b10 : w_req_new;
            if (|Req) begin
                r_pend_vld <= 1'b1;
                r_pend_src <= Req[1] ? 2'd2 : 2'd1;
            end else if (w_frame_bnd) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Snapshot payload needs no reset; its valid flag guards every use.
    always_ff @(posedge CLK) begin
        if (|Req)
            r_pend_data <= Req[1] ? Data2 : Data1;
    end

    assign CLK_S = r_clk_s;
    assign Data  = r_data;
    assign Sel   = r_sel;
    assign Src   = r_src;
    assign Ack   = r_ack;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler with a 16-CLK frame and 32-CLK page.
module tb_seg_display_scheduler;

    localparam int SIG_DATA = 0;
    localparam int SIG_SEL  = 1;
    localparam int SIG_SRC  = 2;
    localparam int SIG_ACK  = 3;
    localparam int SIG_CLKS = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Data0 = 32'd0;
    logic [31:0] Data1 = 32'd0;
    logic [31:0] Data2 = 32'd0;
    logic [1:0]  Req = 2'b00;
    logic        Freeze = 1'b0;
    logic        CLK_S;
    logic [31:0] Data;
    logic        Sel;
    logic [1:0]  Src;
    logic [1:0]  Ack;

    typedef struct {
        int          cyc;
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    seg_display_scheduler #(
        .SCAN_DIV(2),
        .PAGE_SCANS(2),
        .HOLD_PAGES(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Data0(Data0),
        .Data1(Data1),
        .Data2(Data2),
        .Req(Req),
        .Freeze(Freeze),
        .CLK_S(CLK_S),
        .Data(Data),
        .Sel(Sel),
        .Src(Src),
        .Ack(Ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_DATA: return Data;
            SIG_SEL:  return {31'd0, Sel};
            SIG_SRC:  return {30'd0, Src};
            SIG_ACK:  return {30'd0, Ack};
            default:  return {31'd0, CLK_S};
        endcase
    endfunction

    task automatic push(input int c, input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                chk(sb_q[i].tag, observe(sb_q[i].sig), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        #1;
        sb_check();
    endtask

    task automatic run_to(input int n);
        while (cyc < n)
            step();
    endtask

    initial begin
        Data0 = 32'h12345678;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_data", Data, 32'd0);
        chk("rst_src", {30'd0, Src}, 32'd0);
        chk("rst_sel", {31'd0, Sel}, 32'd0);
        chk("rst_clks", {31'd0, CLK_S}, 32'd0);
        chk("rst_ack", {30'd0, Ack}, 32'd0);
        RST = 1'b0;

        // Scan clock rises at CLK 2, 6; Sel toggles at 30 and 62.
        push(1,  "clks_c1",  SIG_CLKS, 32'd0);
        push(1,  "live_d1",  SIG_DATA, 32'h12345678);
        push(2,  "clks_c2",  SIG_CLKS, 32'd1);
        push(4,  "clks_c4",  SIG_CLKS, 32'd0);
        push(6,  "clks_c6",  SIG_CLKS, 32'd1);
        push(8,  "live_d8",  SIG_DATA, 32'h12345678);
        push(9,  "live_d9",  SIG_DATA, 32'hCAFEF00D);
        push(29, "sel_c29",  SIG_SEL,  32'd0);
        push(30, "sel_c30",  SIG_SEL,  32'd1);
        push(61, "sel_c61",  SIG_SEL,  32'd1);
        push(62, "sel_c62",  SIG_SEL,  32'd0);
        run_to(8);
        Data0 = 32'hCAFEF00D;

        // Event 1, Req held three cycles; hold runs 78..142.
        run_to(70);
        Data1 = 32'hDEADBEEF;
        Req   = 2'b01;
        push(71,  "ack1_c71",  SIG_ACK,  32'd1);
        push(72,  "ack1_c72",  SIG_ACK,  32'd0);
        push(73,  "ack1_c73",  SIG_ACK,  32'd0);
        push(77,  "h1_src77",  SIG_SRC,  32'd0);
        push(77,  "h1_d77",    SIG_DATA, 32'hCAFEF00D);
        push(78,  "h1_src78",  SIG_SRC,  32'd1);
        push(78,  "h1_sel78",  SIG_SEL,  32'd0);
        push(78,  "h1_d78",    SIG_DATA, 32'hDEADBEEF);
        push(100, "h1_d100",   SIG_DATA, 32'hDEADBEEF);
        push(109, "h1_sel109", SIG_SEL,  32'd0);
        push(110, "h1_sel110", SIG_SEL,  32'd1);
        push(141, "h1_src141", SIG_SRC,  32'd1);
        push(141, "h1_sel141", SIG_SEL,  32'd1);
        push(142, "h1_src142", SIG_SRC,  32'd0);
        push(142, "h1_sel142", SIG_SEL,  32'd0);
        push(142, "h1_d142",   SIG_DATA, 32'hCAFEF00D);
        run_to(73);
        Req = 2'b00;
        run_to(74);
        Data1 = 32'd0;

        // Both bits set: source 2 wins, then source 1 preempts at 174.
        run_to(150);
        Data1 = 32'h11111111;
        Data2 = 32'h0BADC0DE;
        Req   = 2'b11;
        push(151, "ack2_c151", SIG_ACK,  32'd2);
        push(158, "h2_src158", SIG_SRC,  32'd2);
        push(158, "h2_d158",   SIG_DATA, 32'h0BADC0DE);
        push(171, "pre_ack",   SIG_ACK,  32'd1);
        push(173, "pre_src173", SIG_SRC, 32'd2);
        push(173, "pre_d173",  SIG_DATA, 32'h0BADC0DE);
        push(174, "pre_src174", SIG_SRC, 32'd1);
        push(174, "pre_sel174", SIG_SEL, 32'd0);
        push(174, "pre_d174",  SIG_DATA, 32'h5555AAAA);
        push(205, "pre_sel205", SIG_SEL, 32'd0);
        push(206, "pre_sel206", SIG_SEL, 32'd1);
        push(237, "pre_src237", SIG_SRC, 32'd1);
        push(238, "pre_src238", SIG_SRC, 32'd0);
        push(238, "pre_d238",  SIG_DATA, 32'hCAFEF00D);
        run_to(151);
        Req = 2'b00;
        run_to(160);
        Data2 = 32'd0;
        run_to(170);
        Data1 = 32'h5555AAAA;
        Req   = 2'b01;
        run_to(171);
        Req = 2'b00;

        // Freeze across six frame boundaries delays exit from 318 to 414.
        run_to(250);
        Data2 = 32'h77778888;
        Req   = 2'b10;
        push(251, "fz_ack",    SIG_ACK,  32'd2);
        push(254, "fz_src254", SIG_SRC,  32'd2);
        push(300, "fz_sel300", SIG_SEL,  32'd0);
        push(300, "fz_src300", SIG_SRC,  32'd2);
        push(302, "fz_clks302", SIG_CLKS, 32'd1);
        push(304, "fz_clks304", SIG_CLKS, 32'd0);
        push(318, "fz_src318", SIG_SRC,  32'd2);
        push(318, "fz_sel318", SIG_SEL,  32'd0);
        push(381, "fz_sel381", SIG_SEL,  32'd0);
        push(382, "fz_sel382", SIG_SEL,  32'd1);
        push(413, "fz_src413", SIG_SRC,  32'd2);
        push(414, "fz_src414", SIG_SRC,  32'd0);
        push(414, "fz_d414",   SIG_DATA, 32'hCAFEF00D);
        run_to(251);
        Req = 2'b00;
        run_to(260);
        Freeze = 1'b1;
        run_to(360);
        Freeze = 1'b0;

        // Async reset mid-hold with a request still pending.
        run_to(430);
        Data1 = 32'h99999999;
        Req   = 2'b01;
        push(446, "rh_src446", SIG_SRC,  32'd1);
        push(446, "rh_d446",   SIG_DATA, 32'h99999999);
        push(449, "rh_ack449", SIG_ACK,  32'd2);
        run_to(431);
        Req = 2'b00;
        run_to(448);
        Data2 = 32'h12121212;
        Req   = 2'b10;
        run_to(449);
        Req = 2'b00;
        run_to(450);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_src", {30'd0, Src}, 32'd0);
        chk("arst_data", Data, 32'd0);
        chk("arst_sel", {31'd0, Sel}, 32'd0);
        chk("arst_clks", {31'd0, CLK_S}, 32'd0);
        chk("arst_ack", {30'd0, Ack}, 32'd0);
        run_to(452);
        #2;
        RST = 1'b0;
        push(453, "rr_clks453", SIG_CLKS, 32'd0);
        push(453, "rr_d453",    SIG_DATA, 32'hCAFEF00D);
        push(454, "rr_clks454", SIG_CLKS, 32'd1);
        push(466, "rr_src466",  SIG_SRC,  32'd0);
        push(470, "rr_src470",  SIG_SRC,  32'd0);
        push(470, "rr_d470",    SIG_DATA, 32'hCAFEF00D);
        run_to(472);

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
